fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Decoupled instruction-fetch front end for the 5-stage RV32 pipeline; replaces the single-entry IF stage.
//  Issues pipelined requests to instruction memory, buffers in-order responses with their PCs in a prefetch FIFO,
//  and presents them to IF/ID over a valid/ready handshake. A redirect (branch/jump/trap) flushes the FIFO and discards in-flight responses.
// PARAMETERS
//  XLEN            32     address/PC width
//  RESET_PC        0      PC fetched first after reset
//  FIFO_DEPTH      4      prefetch entries; power of 2, >=2
//  MAX_OUTSTANDING 2      max accepted-but-unanswered imem requests; 1..FIFO_DEPTH
// PORTS
//  clk             in   1     clock, rising edge
//  reset           in   1     asynchronous, active-low reset
//  imem_req_valid  out  1     request to instruction memory
//  imem_req_ready  in   1     memory accepts request this cycle
//  imem_req_addr   out  XLEN  word-aligned fetch address
//  imem_rsp_valid  in   1     response data valid (in order, >=1 cycle after acceptance)
//  imem_rsp_data   in   32    instruction word
//  redirect_valid  in   1     flush and restart fetch (from EX branch resolution)
//  redirect_pc     in   XLEN  new fetch PC; bits [1:0] ignored (forced 0)
//  id_valid        out  1     head of FIFO valid toward IF/ID
//  id_ready        in   1     IF/ID accepts (deasserted on load-use stall)
//  id_pc           out  XLEN  PC of head instruction
//  id_instr        out  32    head instruction
// BEHAVIOUR
//  Reset (async assert, sync release): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0;
//   imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0.
//  Credit rule: imem_req_valid = (outstanding < MAX_OUTSTANDING) && (fifo_count + outstanding - drop_cnt < FIFO_DEPTH).
//   Guarantees FIFO never overflows; no comb path from redirect_valid or id_ready to imem_req_valid.
//  imem_req_addr = fetch_pc. Accept = valid&&ready -> fetch_pc += 4, outstanding += 1 (mod 2^XLEN wrap).
//  Response: outstanding -= 1 every imem_rsp_valid cycle. If drop_cnt!=0 response discarded, drop_cnt -= 1;
//   else push {rsp_pc, data}, rsp_pc += 4.
//  id_valid = FIFO not empty; id_pc/id_instr = head entry; pop on id_valid&&id_ready.
//  Latency: response into empty FIFO -> id_valid next cycle; push+pop same cycle when full is legal (count unchanged).
//  Redirect (registered effect, next cycle):
//   FIFO emptied; fetch_pc, rsp_pc <= {redirect_pc[XLEN-1:2],2'b00};
//   drop_cnt <= outstanding + accept - rsp_valid (all still-in-flight responses, incl. one accepted this cycle) - also drops pending drop_cnt;
//   a same-cycle response is discarded; a same-cycle pop is ignored (flush wins).
//  Back-to-back redirects: last one wins; drop_cnt recomputed each time from in-flight count.
//  imem_rsp_valid with outstanding==0: protocol error, ignored (no push, counters saturate at 0); flagged by assertion.
//  Reset mid-transfer: all state cleared immediately; memory must also be reset.
// STRUCTURE
//  Package rv_fetch_pkg: ILEN=32, INSTR_NOP=32'h0000_0013, PC_STEP=4, fetch_entry_t {pc, instr}.
//  Sub-module fetch_fifo: sync FIFO, DEPTH/WIDTH params, push/pop/flush, count, full/empty, head read comb.
//  Top: PC/rsp_pc registers, outstanding and drop counters, credit logic, fetch_fifo instance.
// TESTING
//  1. Reset release, 0-wait memory, id_ready=1 -> PCs 0,4,8,12 on id_pc in consecutive cycles after 2-cycle fill.
//  2. id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered, imem_req_valid low, no loss on release.
//  3. Redirect to 0x100 with 2 outstanding -> next 2 responses dropped; first id_pc=0x100, then 0x104.
//  4. Redirect same cycle as response and pop -> response dropped, FIFO empty next cycle, id_valid=0.
//  5. Redirect_pc=0x203 -> fetch address 0x200; fetch_pc 0xFFFF_FFFC +4 wraps to 0.
//  6. Random imem_req_ready/rsp latency 1-5, random redirects -> id stream matches golden PC sequence, no overflow.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared constants and types for the RV32 decoupled fetch front end.
package rv_fetch_pkg;

    localparam int unsigned ILEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head entry is read combinationally.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited pipelined imem requests, prefetch FIFO
// toward IF/ID, and redirect flush that discards responses still in flight.
module fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic            credit, accept, rsp_ok;
    logic            push, pop, fifo_full, fifo_empty;
    fetch_entry_t    push_entry, head_entry;

    // Slots already promised: buffered entries plus responses that will still be kept.
    assign in_use = {1'b0, fifo_count} + {1'b0, outstanding_q} - {1'b0, drop_cnt_q};
    assign credit = (outstanding_q < CW'(MAX_OUTSTANDING)) && (in_use < (CW+1)'(FIFO_DEPTH));

    assign imem_req_valid = reset && credit;
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
    assign outstanding_d  = outstanding_q + CW'(accept) - CW'(rsp_ok);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        push       = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rsp_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_d = outstanding_d;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            if (rsp_ok) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_comb begin
        push_entry.pc    = 32'(rsp_pc_q);
        push_entry.instr = imem_rsp_data;
    end

    assign pop = id_valid && id_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign id_valid = !fifo_empty;
    assign id_pc    = id_valid ? XLEN'(head_entry.pc) : '0;
    assign id_instr = id_valid ? head_entry.instr : '0;

    a_rsp_with_credit: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (outstanding_q != '0))
        else $error("fetch_unit: imem response with no request outstanding");

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        push |-> (!fifo_full || pop));

endmodule
